// File: rtl/mul_div_if.sv
// Handshake/bus bundle between the EX stage and the iterative multiply/divide unit.
//   start/op/a/b : request and operands (sampled only while the unit is idle)
//   busy         : operation in flight
//   ready        : one-cycle completion strobe, result valid
//   result       : {hi,lo}
//   abort        : cancel in-flight op (present only with MULDIV_ABORT_EN)
// Optional feature macro: MULDIV_ABORT_EN
interface mul_div_if #(
  parameter int unsigned WIDTH = 32
);
  logic                 start;
  logic [1:0]           op;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 busy;
  logic                 ready;
  logic [2*WIDTH-1:0]   result;
`ifdef MULDIV_ABORT_EN
  logic                 abort;

  modport master (output start, op, a, b, abort, input busy, ready, result);
  modport slave  (input start, op, a, b, abort, output busy, ready, result);
`else
  modport master (output start, op, a, b, input busy, ready, result);
  modport slave  (input start, op, a, b, output busy, ready, result);
`endif
endinterface

// File: rtl/mul_div_unit.sv
// Iterative WIDTH-bit multiply/divide engine (MULT, MULTU, DIV, DIVU).
// One op at a time; WIDTH iterations, one sign-fix cycle, one done cycle.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : mul_div_if.slave (start/op/a/b in, busy/ready/result out, optional abort in)
// Optional feature macro: MULDIV_ABORT_EN (adds bus.abort, cancels an in-flight op)
module mul_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic      clk,
  input  logic      rst_n,
  mul_div_if.slave  bus
);

  localparam int unsigned RES_W = 2 * WIDTH;
  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               is_div_q, is_div_d;
  logic               neg_res_q, neg_res_d;   // negate product / quotient
  logic               neg_rem_q, neg_rem_d;   // remainder follows sign(a)
  logic               bzero_q, bzero_d;
  logic [WIDTH-1:0]   a_q, a_d;               // original dividend for divide-by-zero
  logic [WIDTH-1:0]   mag_b_q, mag_b_d;       // multiplicand / divisor magnitude
  logic [RES_W-1:0]   acc_q, acc_d;           // product, or {unused, dividend->quotient}
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic               busy_q, busy_d;
  logic               ready_q, ready_d;
  logic [RES_W-1:0]   result_q, result_d;

  logic               abort_req;
  logic               sgn_op;
  logic               sa, sb;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_trial;
  logic [WIDTH:0]     div_diff;
  logic [WIDTH-1:0]   quo, quo_fix, rem_fix;
  logic [RES_W-1:0]   fix_val;

`ifdef MULDIV_ABORT_EN
  assign abort_req = bus.abort;
`else
  assign abort_req = 1'b0;
`endif

  // Operand magnitudes and sign flags captured at accept
  assign sgn_op = ~bus.op[0];
  assign sa     = sgn_op & bus.a[WIDTH-1];
  assign sb     = sgn_op & bus.b[WIDTH-1];
  assign mag_a  = sa ? (WIDTH'(0) - bus.a) : bus.a;
  assign mag_b  = sb ? (WIDTH'(0) - bus.b) : bus.b;

  // Multiply step: conditionally add multiplicand into the high half, then shift right
  assign mul_sum = {1'b0, acc_q[RES_W-1:WIDTH]}
                 + (acc_q[0] ? {1'b0, mag_b_q} : (WIDTH+1)'(0));

  // Restoring divide step: shift next dividend bit into the partial remainder
  assign div_trial = {rem_q, acc_q[WIDTH-1]};
  assign div_diff  = div_trial - {1'b0, mag_b_q};

  // Sign fix-up; divide-by-zero bypasses it and reports {a, all ones}
  assign quo     = acc_q[WIDTH-1:0];
  assign quo_fix = neg_res_q ? (WIDTH'(0) - quo) : quo;
  assign rem_fix = neg_rem_q ? (WIDTH'(0) - rem_q) : rem_q;

  always_comb begin
    fix_val = neg_res_q ? (RES_W'(0) - acc_q) : acc_q;
    if (is_div_q) begin
      fix_val = bzero_q ? {a_q, {WIDTH{1'b1}}} : {rem_fix, quo_fix};
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    bzero_d   = bzero_q;
    a_d       = a_q;
    mag_b_d   = mag_b_q;
    acc_d     = acc_q;
    rem_d     = rem_q;
    result_d  = result_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start && !abort_req) begin
          is_div_d  = bus.op[1];
          neg_res_d = sa ^ sb;
          neg_rem_d = sa;
          bzero_d   = (bus.b == WIDTH'(0));
          a_d       = bus.a;
          mag_b_d   = mag_b;
          acc_d     = {WIDTH'(0), mag_a};
          rem_d     = WIDTH'(0);
          cnt_d     = CNT_W'(WIDTH - 1);
          state_d   = S_CALC;
        end
      end
      S_CALC: begin
        if (is_div_q) begin
          if (!div_diff[WIDTH]) begin
            rem_d = div_diff[WIDTH-1:0];
          end else begin
            rem_d = div_trial[WIDTH-1:0];
          end
          acc_d = {acc_q[RES_W-1:WIDTH], acc_q[WIDTH-2:0], ~div_diff[WIDTH]};
        end else begin
          acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(0)) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        result_d = fix_val;
        state_d  = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort wins over everything; result keeps its previous value
    if (abort_req) begin
      state_d  = S_IDLE;
      result_d = result_q;
    end

    busy_d  = (state_d != S_IDLE);
    ready_d = (state_d == S_DONE);
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= CNT_W'(0);
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      bzero_q   <= 1'b0;
      a_q       <= WIDTH'(0);
      mag_b_q   <= WIDTH'(0);
      acc_q     <= RES_W'(0);
      rem_q     <= WIDTH'(0);
      busy_q    <= 1'b0;
      ready_q   <= 1'b0;
      result_q  <= RES_W'(0);
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      bzero_q   <= bzero_d;
      a_q       <= a_d;
      mag_b_q   <= mag_b_d;
      acc_q     <= acc_d;
      rem_q     <= rem_d;
      busy_q    <= busy_d;
      ready_q   <= ready_d;
      result_q  <= result_d;
    end
  end

  assign bus.busy   = busy_q;
  assign bus.ready  = ready_q;
  assign bus.result = result_q;

endmodule
